// File: rtl/async_mem_ctrl.sv
// Asynchronous SRAM bus controller: multi-bank decode, byte-enable writes,
// programmable read wait states and write setup/pulse/recovery timing.
module async_mem_ctrl #(
  parameter int DATA_W      = 32,
  parameter int BANK_ADDR_W = 20,
  parameter int N_BANKS     = 2,
  parameter int RD_WAIT     = 1,
  parameter int WR_SETUP    = 0,
  parameter int WR_WIDTH    = 1,
  parameter int WR_RECOVERY = 1
) (
  input  logic                   clk50M,
  input  logic                   rst,
  input  logic                   req_valid,
  input  logic                   req_write,
  input  logic [31:0]            req_addr,
  input  logic [DATA_W-1:0]      req_wdata,
  input  logic [DATA_W/8-1:0]    req_be,
  output logic                   req_ready,
  output logic                   resp_valid,
  output logic                   resp_err,
  output logic [DATA_W-1:0]      resp_rdata,
  output logic [BANK_ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0]      mem_dq_o,
  output logic                   mem_dq_oe,
  input  logic [DATA_W-1:0]      mem_dq_i,
  output logic [N_BANKS-1:0]     mem_ce_n,
  output logic                   mem_oe_n,
  output logic                   mem_we_n,
  output logic [DATA_W/8-1:0]    mem_be_n
);

  localparam int          BE_W     = DATA_W / 8;
  localparam int          OFF_W    = $clog2(BE_W);
  localparam int          BANK_W   = (N_BANKS > 1) ? $clog2(N_BANKS) : 1;
  localparam logic [63:0] WA_LIMIT = 64'(N_BANKS) << BANK_ADDR_W;
  localparam logic [3:0]  RD_CNT   = 4'(RD_WAIT);
  localparam logic [3:0]  SU_CNT   = 4'(WR_SETUP - 1);
  localparam logic [3:0]  PW_CNT   = 4'(WR_WIDTH - 1);
  localparam logic [3:0]  REC_CNT  = 4'(WR_RECOVERY - 1);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WR_SU, S_WR_PW, S_WR_REC, S_ERR} state_e;

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [BANK_ADDR_W-1:0] addr_q, addr_d;
  logic [BANK_W-1:0]      bank_q, bank_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic [BE_W-1:0]        be_q, be_d;
  logic                   ready_q, ready_d;
  logic                   rvalid_q, rvalid_d;
  logic                   rerr_q, rerr_d;
  logic [DATA_W-1:0]      rdata_q, rdata_d;
  logic [BANK_ADDR_W-1:0] maddr_q, maddr_d;
  logic [DATA_W-1:0]      dqo_q, dqo_d;
  logic                   dqoe_q, dqoe_d;
  logic [N_BANKS-1:0]     ce_n_q, ce_n_d;
  logic                   oe_n_q, oe_n_d;
  logic                   we_n_q, we_n_d;
  logic [BE_W-1:0]        be_n_q, be_n_d;

  logic [31:0]       wa;
  logic              in_range;
  logic [BANK_W-1:0] req_bank;
  logic              last;

  assign wa       = req_addr >> OFF_W;
  assign in_range = {32'b0, wa} < WA_LIMIT;
  assign req_bank = BANK_W'((wa >> BANK_ADDR_W) & 32'(N_BANKS - 1));
  assign last     = (cnt_q == 4'd0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    bank_d   = bank_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    rvalid_d = 1'b0;
    rerr_d   = 1'b0;
    rdata_d  = rdata_q;
    case (state_q)
      S_IDLE: if (req_valid && ready_q) begin
        addr_d  = wa[BANK_ADDR_W-1:0];
        bank_d  = req_bank;
        wdata_d = req_wdata;
        be_d    = req_be;
        cnt_d   = 4'd0;
        if (!in_range)            state_d = S_ERR;
        else if (!req_write)      begin state_d = S_RD;    cnt_d = RD_CNT; end
        else if (WR_SETUP > 0)    begin state_d = S_WR_SU; cnt_d = SU_CNT; end
        else                      begin state_d = S_WR_PW; cnt_d = PW_CNT; end
      end
      S_RD: if (last) begin
        // CE/OE are still low on this edge, so the pads hold valid data
        state_d  = S_IDLE;
        rvalid_d = 1'b1;
        rdata_d  = mem_dq_i;
      end else cnt_d = cnt_q - 4'd1;
      S_WR_SU: if (last) begin
        state_d = S_WR_PW;
        cnt_d   = PW_CNT;
      end else cnt_d = cnt_q - 4'd1;
      S_WR_PW: if (last) begin
        if (WR_RECOVERY > 0) begin
          state_d = S_WR_REC;
          cnt_d   = REC_CNT;
        end else begin
          state_d  = S_IDLE;
          rvalid_d = 1'b1;
        end
      end else cnt_d = cnt_q - 4'd1;
      S_WR_REC: if (last) begin
        state_d  = S_IDLE;
        rvalid_d = 1'b1;
      end else cnt_d = cnt_q - 4'd1;
      S_ERR: begin
        state_d  = S_IDLE;
        cnt_d    = 4'd0;
        rvalid_d = 1'b1;
        rerr_d   = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Bus outputs are a registered function of the next state
    ready_d = (state_d == S_IDLE);
    maddr_d = '0;
    dqo_d   = '0;
    dqoe_d  = 1'b0;
    ce_n_d  = '1;
    oe_n_d  = 1'b1;
    we_n_d  = 1'b1;
    be_n_d  = '1;
    case (state_d)
      S_RD: begin
        maddr_d        = addr_d;
        ce_n_d[bank_d] = 1'b0;
        oe_n_d         = 1'b0;
        be_n_d         = '0;
      end
      S_WR_SU, S_WR_PW, S_WR_REC: begin
        maddr_d        = addr_d;
        ce_n_d[bank_d] = 1'b0;
        dqoe_d         = 1'b1;
        dqo_d          = wdata_d;
        be_n_d         = ~be_d;
        we_n_d         = (state_d != S_WR_PW);
      end
      default: ;
    endcase
  end

  always_ff @(negedge clk50M) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      addr_q   <= '0;
      bank_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      ready_q  <= 1'b0;
      rvalid_q <= 1'b0;
      rerr_q   <= 1'b0;
      rdata_q  <= '0;
      maddr_q  <= '0;
      dqo_q    <= '0;
      dqoe_q   <= 1'b0;
      ce_n_q   <= '1;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      be_n_q   <= '1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      bank_q   <= bank_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      ready_q  <= ready_d;
      rvalid_q <= rvalid_d;
      rerr_q   <= rerr_d;
      rdata_q  <= rdata_d;
      maddr_q  <= maddr_d;
      dqo_q    <= dqo_d;
      dqoe_q   <= dqoe_d;
      ce_n_q   <= ce_n_d;
      oe_n_q   <= oe_n_d;
      we_n_q   <= we_n_d;
      be_n_q   <= be_n_d;
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = rvalid_q;
  assign resp_err   = rerr_q;
  assign resp_rdata = rdata_q;
  assign mem_addr   = maddr_q;
  assign mem_dq_o   = dqo_q;
  assign mem_dq_oe  = dqoe_q;
  assign mem_ce_n   = ce_n_q;
  assign mem_oe_n   = oe_n_q;
  assign mem_we_n   = we_n_q;
  assign mem_be_n   = be_n_q;

endmodule

// File: tb/tb_async_mem_ctrl.sv
// Directed bench for async_mem_ctrl: default-parameter instance plus a
// slow-timing four-bank instance driven back-to-back.
module tb_async_mem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // default-parameter instance
  logic        rst, valid, write, ready, rvalid, rerr, dqoe, oe_n, we_n;
  logic [31:0] addr, wdata, rdata, dq_o, dq_i, rd_val;
  logic [3:0]  be, be_n;
  logic [19:0] maddr;
  logic [1:0]  ce_n;

  assign dq_i = oe_n ? 32'h0 : rd_val;

  async_mem_ctrl u_dut (
    .clk50M(clk), .rst(rst), .req_valid(valid), .req_write(write), .req_addr(addr),
    .req_wdata(wdata), .req_be(be), .req_ready(ready), .resp_valid(rvalid),
    .resp_err(rerr), .resp_rdata(rdata), .mem_addr(maddr), .mem_dq_o(dq_o),
    .mem_dq_oe(dqoe), .mem_dq_i(dq_i), .mem_ce_n(ce_n), .mem_oe_n(oe_n),
    .mem_we_n(we_n), .mem_be_n(be_n)
  );

  // slow-timing four-bank instance
  logic        valid2, write2, ready2, rvalid2, rerr2, dqoe2, oe_n2, we_n2;
  logic [31:0] addr2, wdata2, rdata2, dq_o2, dq_i2;
  logic [3:0]  be2, be_n2, ce_n2;
  logic [19:0] maddr2;

  assign dq_i2 = oe_n2 ? 32'h0 : (32'hA500_0000 | 32'(maddr2));

  async_mem_ctrl #(.RD_WAIT(3), .WR_SETUP(1), .WR_WIDTH(2), .WR_RECOVERY(2), .N_BANKS(4)) u_dut2 (
    .clk50M(clk), .rst(rst), .req_valid(valid2), .req_write(write2), .req_addr(addr2),
    .req_wdata(wdata2), .req_be(be2), .req_ready(ready2), .resp_valid(rvalid2),
    .resp_err(rerr2), .resp_rdata(rdata2), .mem_addr(maddr2), .mem_dq_o(dq_o2),
    .mem_dq_oe(dqoe2), .mem_dq_i(dq_i2), .mem_ce_n(ce_n2), .mem_oe_n(oe_n2),
    .mem_we_n(we_n2), .mem_be_n(be_n2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // one active (falling) edge, then sample on the following rising edge
  task automatic tick();
    @(posedge clk);
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".ce_n"}, 64'(ce_n), 64'h3);
    check({tag, ".oe_n"}, 64'(oe_n), 64'h1);
    check({tag, ".we_n"}, 64'(we_n), 64'h1);
    check({tag, ".be_n"}, 64'(be_n), 64'hF);
    check({tag, ".dq_oe"}, 64'(dqoe), 64'h0);
    check({tag, ".addr"}, 64'(maddr), 64'h0);
    check({tag, ".dq_o"}, 64'(dq_o), 64'h0);
  endtask

  initial begin
    rst = 1'b1; valid = 1'b1; write = 1'b0; addr = 32'h10; wdata = '0; be = '0; rd_val = '0;
    valid2 = 1'b0; write2 = 1'b0; addr2 = '0; wdata2 = '0; be2 = '0;

    // reset held for three active edges with a request pending
    repeat (4) tick();
    check_idle("rst");
    check("rst.ready", 64'(ready), 64'h0);
    check("rst.rvalid", 64'(rvalid), 64'h0);
    check("rst.rerr", 64'(rerr), 64'h0);
    check("rst.rdata", 64'(rdata), 64'h0);
    rst = 1'b0; valid = 1'b0;
    tick();
    check("rel.ready", 64'(ready), 64'h1);
    check("rel.rvalid", 64'(rvalid), 64'h0);

    // read 0x10 -> bank 0, word 4
    valid = 1'b1; write = 1'b0; addr = 32'h0000_0010; rd_val = 32'hDEAD_BEEF;
    tick(); valid = 1'b0;
    check("rd.e0.ready", 64'(ready), 64'h0);
    check("rd.e0.ce_n", 64'(ce_n), 64'h2);
    check("rd.e0.oe_n", 64'(oe_n), 64'h0);
    check("rd.e0.addr", 64'(maddr), 64'h4);
    check("rd.e0.be_n", 64'(be_n), 64'h0);
    check("rd.e0.dq_oe", 64'(dqoe), 64'h0);
    check("rd.e0.rvalid", 64'(rvalid), 64'h0);
    tick();
    check("rd.e1.oe_n", 64'(oe_n), 64'h0);
    check("rd.e1.ce_n", 64'(ce_n), 64'h2);
    check("rd.e1.rvalid", 64'(rvalid), 64'h0);
    tick();
    check_idle("rd.e2");
    check("rd.e2.rvalid", 64'(rvalid), 64'h1);
    check("rd.e2.rerr", 64'(rerr), 64'h0);
    check("rd.e2.rdata", 64'(rdata), 64'hDEAD_BEEF);
    check("rd.e2.ready", 64'(ready), 64'h1);
    rd_val = 32'h0BAD_F00D;
    tick();
    check("rd.e3.rvalid", 64'(rvalid), 64'h0);
    check("rd.e3.rdata", 64'(rdata), 64'hDEAD_BEEF);

    // write 0x00400008 -> bank 1, word 2
    valid = 1'b1; write = 1'b1; addr = 32'h0040_0008; wdata = 32'h1234_5678; be = 4'b0011;
    tick(); valid = 1'b0; wdata = '0; be = '0;
    check("wr.e0.we_n", 64'(we_n), 64'h0);
    check("wr.e0.ce_n", 64'(ce_n), 64'h1);
    check("wr.e0.addr", 64'(maddr), 64'h2);
    check("wr.e0.be_n", 64'(be_n), 64'hC);
    check("wr.e0.dq_oe", 64'(dqoe), 64'h1);
    check("wr.e0.dq_o", 64'(dq_o), 64'h1234_5678);
    check("wr.e0.oe_n", 64'(oe_n), 64'h1);
    tick();
    check("wr.e1.we_n", 64'(we_n), 64'h1);
    check("wr.e1.ce_n", 64'(ce_n), 64'h1);
    check("wr.e1.dq_oe", 64'(dqoe), 64'h1);
    check("wr.e1.dq_o", 64'(dq_o), 64'h1234_5678);
    check("wr.e1.be_n", 64'(be_n), 64'hC);
    check("wr.e1.rvalid", 64'(rvalid), 64'h0);
    tick();
    check_idle("wr.e2");
    check("wr.e2.rvalid", 64'(rvalid), 64'h1);
    check("wr.e2.rerr", 64'(rerr), 64'h0);
    check("wr.e2.rdata", 64'(rdata), 64'hDEAD_BEEF);

    // out-of-range read then write
    for (int w = 0; w < 2; w++) begin
      valid = 1'b1; write = w[0]; addr = 32'h0080_0000; wdata = 32'hFFFF_FFFF; be = 4'hF;
      tick(); valid = 1'b0;
      check_idle("oor.e0");
      check("oor.e0.ready", 64'(ready), 64'h0);
      check("oor.e0.rvalid", 64'(rvalid), 64'h0);
      tick();
      check_idle("oor.e1");
      check("oor.e1.rvalid", 64'(rvalid), 64'h1);
      check("oor.e1.rerr", 64'(rerr), 64'h1);
      check("oor.e1.rdata", 64'(rdata), 64'hDEAD_BEEF);
    end

    // reset during the write pulse
    valid = 1'b1; write = 1'b1; addr = 32'h0000_0020; wdata = 32'hA5A5_5A5A; be = 4'hF;
    tick(); valid = 1'b0;
    check("mid.pw.we_n", 64'(we_n), 64'h0);
    rst = 1'b1;
    tick();
    check_idle("mid.rst");
    check("mid.rst.rvalid", 64'(rvalid), 64'h0);
    check("mid.rst.ready", 64'(ready), 64'h0);
    rst = 1'b0;
    tick();
    check("mid.rel.ready", 64'(ready), 64'h1);
    check("mid.rel.rvalid", 64'(rvalid), 64'h0);
    tick();
    check("mid.idle.rvalid", 64'(rvalid), 64'h0);
    check("mid.idle.we_n", 64'(we_n), 64'h1);

    // back-to-back read/write/read on the slow four-bank instance
    check("b2b.ready0", 64'(ready2), 64'h1);
    valid2 = 1'b1; write2 = 1'b0; addr2 = 32'h0080_0014;
    begin
      int nreq = 1;
      for (int k = 0; k < 17; k++) begin
        logic       oe_lo, we_lo, rv;
        logic [3:0] ce_exp;
        tick();
        oe_lo  = (k <= 3) || (k >= 11 && k <= 14);
        we_lo  = (k == 6) || (k == 7);
        rv     = (k == 4) || (k == 10) || (k == 15);
        ce_exp = (k <= 3) ? 4'b1011 : (k >= 5 && k <= 9) ? 4'b0111 :
                 (k >= 11 && k <= 14) ? 4'b1101 : 4'b1111;
        check($sformatf("b2b.k%0d.oe_n", k), 64'(oe_n2), 64'(!oe_lo));
        check($sformatf("b2b.k%0d.we_n", k), 64'(we_n2), 64'(!we_lo));
        check($sformatf("b2b.k%0d.ce_n", k), 64'(ce_n2), 64'(ce_exp));
        check($sformatf("b2b.k%0d.rvalid", k), 64'(rvalid2), 64'(rv));
        check($sformatf("b2b.k%0d.ready", k), 64'(ready2), 64'(rv || k == 16));
        if (k == 4)  check("b2b.rd0.rdata", 64'(rdata2), 64'hA500_0005);
        if (k == 15) check("b2b.rd1.rdata", 64'(rdata2), 64'hA500_0001);
        if (k == 7) begin
          check("b2b.wr.addr", 64'(maddr2), 64'h7);
          check("b2b.wr.dq_o", 64'(dq_o2), 64'hCAFE_F00D);
          check("b2b.wr.be_n", 64'(be_n2), 64'h5);
        end
        if (k == 5) check("b2b.wr.su.dq_oe", 64'(dqoe2), 64'h1);
        if (k == 9) check("b2b.wr.rec.dq_o", 64'(dq_o2), 64'hCAFE_F00D);
        if (ready2) begin
          case (nreq)
            1: begin write2 = 1'b1; addr2 = 32'h00C0_001C; wdata2 = 32'hCAFE_F00D; be2 = 4'b1010; end
            2: begin write2 = 1'b0; addr2 = 32'h0040_0004; wdata2 = '0; be2 = '0; end
            default: valid2 = 1'b0;
          endcase
          nreq++;
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
